// File: rtl/aemb2_xslv_pkg.sv
// Shared types and constants for the XWB FIFO bridge: bus FSM states,
// status-word field layout and channel-count derivation.
package aemb2_xslv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } xwb_state_t;

    // Status word layout: RX non-empty flags in the low byte,
    // TX non-full flags in the next byte, upper half zero.
    localparam int STAT_RX_LSB = 0;
    localparam int STAT_TX_LSB = 8;
    localparam int STAT_FLD_W  = 8;

    function automatic int nch_of(input int aemb_xwb);
        return 1 << aemb_xwb;
    endfunction

endpackage

// File: rtl/aemb2_xslv_fifo.sv
// Synchronous show-ahead FIFO. The head word is always visible on dout.
// Full/empty come from a registered occupancy count, so a push into a full
// FIFO is refused even when a pop happens in the same cycle. nfull_q is a
// registered "will not be full" flag that is low during reset, used as a
// stream-side ready.
module aemb2_xslv_fifo
    import aemb2_xslv_pkg::*;
#(
    parameter int DW      = 32,
    parameter int FIFO_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DW-1:0]     din,
    output logic [DW-1:0]     dout,
    output logic              full,
    output logic              empty,
    output logic [FIFO_AW:0]  count,
    output logic              nfull_q
);

    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [DW-1:0]      mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count_nxt;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointers, count and registered ready; reset discards contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            nfull_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nxt;
            nfull_q <= (count_nxt != FULL_CNT);
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/aemb2_xslv_fifo_bridge.sv
// XWB responder bridging core put/get cycles to per-channel accelerator
// streams. Each channel owns a TX FIFO (tag+data) and an RX FIFO. The core is
// stalled by withholding ack until the addressed FIFO can serve.
// Optional build macro AEMB2_XSLV_STAT_EN turns the highest channel into a
// read-only status register instead of a FIFO pair.
module aemb2_xslv_fifo_bridge
    import aemb2_xslv_pkg::*;
#(
    parameter int AEMB_XWB = 3,
    parameter int FIFO_AW  = 2
) (
    input  logic                           sys_clk_i,
    input  logic                           sys_rst_i,
    input  logic [AEMB_XWB-1:0]            xwb_adr_i,
    input  logic                           xwb_cyc_i,
    input  logic                           xwb_stb_i,
    input  logic                           xwb_wre_i,
    input  logic                           xwb_tag_i,
    input  logic [3:0]                     xwb_sel_i,
    input  logic [31:0]                    xwb_dat_i,
    output logic                           xwb_ack_o,
    output logic [31:0]                    xwb_dat_o,
    output logic [32*(2**AEMB_XWB)-1:0]    acc_dat_o,
    output logic [(2**AEMB_XWB)-1:0]       acc_tag_o,
    output logic [(2**AEMB_XWB)-1:0]       acc_vld_o,
    input  logic [(2**AEMB_XWB)-1:0]       acc_rdy_i,
    input  logic [32*(2**AEMB_XWB)-1:0]    acc_dat_i,
    input  logic [(2**AEMB_XWB)-1:0]       acc_vld_i,
    output logic [(2**AEMB_XWB)-1:0]       acc_rdy_o
);

    localparam int NCH   = nch_of(AEMB_XWB);
    localparam int NSTAT = (NCH - 1 < STAT_FLD_W) ? NCH - 1 : STAT_FLD_W;
    localparam logic [AEMB_XWB-1:0] STAT_CH = '1;

`ifdef AEMB2_XSLV_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    xwb_state_t     state_q;
    xwb_state_t     state_d;
    logic           req;
    logic           ready;
    logic           serve;
    logic           stat_sel;
    logic [31:0]    stat_word;
    logic [NCH-1:0] tx_full;
    logic [NCH-1:0] rx_empty;
    logic [31:0]    rx_head [NCH];
    logic           unused_sel;

    assign unused_sel = ^xwb_sel_i;
    assign req        = xwb_cyc_i && xwb_stb_i;
    assign stat_sel   = STAT_EN && (xwb_adr_i == STAT_CH);
    assign xwb_ack_o  = (state_q == ST_ACK);

    // Next-state and serve decision: a request is served on the edge where
    // the addressed FIFO can take/give a word; ACK always returns to IDLE so
    // a lagging strobe is never served twice.
    always_comb begin
        state_d = state_q;
        serve   = 1'b0;
        ready   = xwb_wre_i ? !tx_full[xwb_adr_i] : !rx_empty[xwb_adr_i];
        if (stat_sel) begin
            ready = 1'b1;
        end
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (ready) begin
                    serve   = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Status snapshot: per-channel TX not-full and RX not-empty flags,
    // excluding the status channel itself.
    always_comb begin
        stat_word = '0;
        for (int i = 0; i < NSTAT; i++) begin
            stat_word[STAT_TX_LSB + i] = ~tx_full[i];
            stat_word[STAT_RX_LSB + i] = ~rx_empty[i];
        end
    end

    // Get data is captured on the serve edge and presented with ack.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            xwb_dat_o <= '0;
        end else if (serve && !xwb_wre_i) begin
            xwb_dat_o <= stat_sel ? stat_word : rx_head[xwb_adr_i];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        if (STAT_EN && (g == NCH - 1)) begin : g_stat
            logic unused_acc;
            assign unused_acc = ^{acc_dat_i[g*32 +: 32], acc_vld_i[g], acc_rdy_i[g]};
            assign tx_full[g]            = 1'b0;
            assign rx_empty[g]           = 1'b1;
            assign rx_head[g]            = '0;
            assign acc_vld_o[g]          = 1'b0;
            assign acc_rdy_o[g]          = 1'b0;
            assign acc_tag_o[g]          = 1'b0;
            assign acc_dat_o[g*32 +: 32] = '0;
        end else begin : g_fifo
            logic             sel;
            logic             tx_push;
            logic             rx_pop;
            logic             rx_push;
            logic             tx_empty;
            logic [32:0]      tx_head;
            logic [FIFO_AW:0] unused_tx_cnt;
            logic [FIFO_AW:0] unused_rx_cnt;
            logic             unused_tx_nfull;
            logic             unused_rx_full;

            assign sel     = (xwb_adr_i == AEMB_XWB'(g));
            assign tx_push = serve && xwb_wre_i && sel;
            assign rx_pop  = serve && !xwb_wre_i && sel;
            assign rx_push = acc_vld_i[g] && acc_rdy_o[g];

            aemb2_xslv_fifo #(.DW(33), .FIFO_AW(FIFO_AW)) u_tx (
                .clk     (sys_clk_i),
                .rst     (sys_rst_i),
                .push    (tx_push),
                .pop     (acc_rdy_i[g]),
                .din     ({xwb_tag_i, xwb_dat_i}),
                .dout    (tx_head),
                .full    (tx_full[g]),
                .empty   (tx_empty),
                .count   (unused_tx_cnt),
                .nfull_q (unused_tx_nfull)
            );

            aemb2_xslv_fifo #(.DW(32), .FIFO_AW(FIFO_AW)) u_rx (
                .clk     (sys_clk_i),
                .rst     (sys_rst_i),
                .push    (rx_push),
                .pop     (rx_pop),
                .din     (acc_dat_i[g*32 +: 32]),
                .dout    (rx_head[g]),
                .full    (unused_rx_full),
                .empty   (rx_empty[g]),
                .count   (unused_rx_cnt),
                .nfull_q (acc_rdy_o[g])
            );

            assign acc_vld_o[g]          = !tx_empty;
            assign acc_tag_o[g]          = tx_head[32];
            assign acc_dat_o[g*32 +: 32] = tx_head[31:0];
        end
    end

endmodule

// File: tb/tb_aemb2_xslv_fifo_bridge.sv
// Scoreboard bench for aemb2_xslv_fifo_bridge. Bus transactions queue their
// expected response; a negedge monitor retires them on ack against a
// queue-based reference model of every channel's TX and RX FIFO.
// Honours AEMB2_XSLV_STAT_EN when defined.
module tb_aemb2_xslv_fifo_bridge;

    localparam int AEMB_XWB = 3;
    localparam int FIFO_AW  = 2;
    localparam int NCH      = 8;
    localparam int DEPTH    = 4;

`ifdef AEMB2_XSLV_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif
    localparam int NFIFO = STAT_EN ? NCH - 1 : NCH;

    typedef struct {
        bit          is_get;
        bit          is_stat;
        int          ch;
        logic [31:0] dat;
        bit          tag;
    } exp_t;

    logic                sys_clk_i = 1'b0;
    logic                sys_rst_i = 1'b1;
    logic [AEMB_XWB-1:0] xwb_adr_i = '0;
    logic                xwb_cyc_i = 1'b0;
    logic                xwb_stb_i = 1'b0;
    logic                xwb_wre_i = 1'b0;
    logic                xwb_tag_i = 1'b0;
    logic [3:0]          xwb_sel_i = 4'hF;
    logic [31:0]         xwb_dat_i = '0;
    logic                xwb_ack_o;
    logic [31:0]         xwb_dat_o;
    logic [32*NCH-1:0]   acc_dat_o;
    logic [NCH-1:0]      acc_tag_o;
    logic [NCH-1:0]      acc_vld_o;
    logic [NCH-1:0]      acc_rdy_i = '0;
    logic [32*NCH-1:0]   acc_dat_i = '0;
    logic [NCH-1:0]      acc_vld_i = '0;
    logic [NCH-1:0]      acc_rdy_o;

    exp_t        exp_q [$];
    logic [32:0] tx_q [NCH][$];
    logic [31:0] rx_q [NCH][$];
    int          n_vec  = 0;
    int          n_err  = 0;
    bit          chk_en = 1'b0;
    int          lat;

    aemb2_xslv_fifo_bridge #(.AEMB_XWB(AEMB_XWB), .FIFO_AW(FIFO_AW)) dut (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .xwb_adr_i (xwb_adr_i),
        .xwb_cyc_i (xwb_cyc_i),
        .xwb_stb_i (xwb_stb_i),
        .xwb_wre_i (xwb_wre_i),
        .xwb_tag_i (xwb_tag_i),
        .xwb_sel_i (xwb_sel_i),
        .xwb_dat_i (xwb_dat_i),
        .xwb_ack_o (xwb_ack_o),
        .xwb_dat_o (xwb_dat_o),
        .acc_dat_o (acc_dat_o),
        .acc_tag_o (acc_tag_o),
        .acc_vld_o (acc_vld_o),
        .acc_rdy_i (acc_rdy_i),
        .acc_dat_i (acc_dat_i),
        .acc_vld_i (acc_vld_i),
        .acc_rdy_o (acc_rdy_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Status word as the model sees the FIFOs: TX not-full and RX not-empty.
    function automatic logic [31:0] statModel();
        logic [31:0] w = '0;
        for (int c = 0; c < NFIFO && c < 8; c++) begin
            w[8 + c] = (tx_q[c].size() < DEPTH);
            w[c]     = (rx_q[c].size() > 0);
        end
        return w;
    endfunction

    // One bus cycle; returns the number of edges until ack, or -1 if the
    // bound ran out. Called and returns just after a rising edge.
    task automatic applyStimulus(input bit wre, input int ch, input logic [31:0] dat,
                                 input bit tag, input bit expect_ack, input int bound,
                                 output int lat_o);
        exp_t e;
        e.is_get  = !wre;
        e.is_stat = STAT_EN && (ch == NCH - 1);
        e.ch      = ch;
        e.dat     = dat;
        e.tag     = tag;
        if (expect_ack) exp_q.push_back(e);
        xwb_adr_i = AEMB_XWB'(ch);
        xwb_wre_i = wre;
        xwb_dat_i = dat;
        xwb_tag_i = tag;
        xwb_sel_i = 4'hF;
        xwb_cyc_i = 1'b1;
        xwb_stb_i = 1'b1;
        lat_o = -1;
        for (int n = 1; n <= bound; n++) begin
            @(posedge sys_clk_i);
            @(negedge sys_clk_i);
            if (xwb_ack_o) begin
                lat_o = n;
                break;
            end
        end
        xwb_cyc_i = 1'b0;
        xwb_stb_i = 1'b0;
        if (expect_ack && lat_o == -1 && exp_q.size() > 0) void'(exp_q.pop_back());
        @(posedge sys_clk_i);
        #1;
    endtask

    // Accelerator offers one RX word for one cycle; model gains it after the edge.
    task automatic accPush(input int ch, input logic [31:0] d);
        checkOutput($sformatf("acc_rdy_pre[%0d]", ch), 64'(acc_rdy_o[ch]), 64'd1);
        acc_dat_i[ch*32 +: 32] = d;
        acc_vld_i[ch] = 1'b1;
        @(posedge sys_clk_i);
        #1;
        acc_vld_i[ch] = 1'b0;
        rx_q[ch].push_back(d);
    endtask

    // One-cycle reset with checks of the reset values while it is applied.
    task automatic doReset();
        chk_en    = 1'b0;
        sys_rst_i = 1'b1;
        @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        checkOutput("rst_ack", 64'(xwb_ack_o), 64'd0);
        checkOutput("rst_dat", 64'(xwb_dat_o), 64'd0);
        checkOutput("rst_vld", 64'(acc_vld_o), 64'd0);
        checkOutput("rst_rdy", 64'(acc_rdy_o), 64'd0);
        sys_rst_i = 1'b0;
        exp_q.delete();
        for (int c = 0; c < NCH; c++) begin
            tx_q[c].delete();
            rx_q[c].delete();
        end
        @(posedge sys_clk_i);
        @(posedge sys_clk_i);
        #1;
        checkOutput("post_rst_rdy", 64'(acc_rdy_o), 64'((1 << NFIFO) - 1));
        chk_en = 1'b1;
    endtask

    // Monitor: retire acks against the scoreboard, check stream flags against
    // the model, and compare TX heads taken by the accelerator.
    always @(negedge sys_clk_i) begin
        exp_t        e;
        logic [31:0] want;
        logic [32:0] head;
        if (xwb_ack_o) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_ack", 64'(xwb_ack_o), 64'd0);
            end else begin
                e = exp_q.pop_front();
                if (!e.is_get) begin
                    if (!e.is_stat) tx_q[e.ch].push_back({e.tag, e.dat});
                end else if (e.is_stat) begin
                    want = statModel();
                    checkOutput("stat_get", 64'(xwb_dat_o), 64'(want));
                end else if (rx_q[e.ch].size() == 0) begin
                    checkOutput("get_on_empty", 64'(xwb_ack_o), 64'd0);
                end else begin
                    want = rx_q[e.ch].pop_front();
                    checkOutput($sformatf("get_dat[%0d]", e.ch), 64'(xwb_dat_o), 64'(want));
                end
            end
        end
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                checkOutput($sformatf("acc_vld[%0d]", c), 64'(acc_vld_o[c]),
                            64'(tx_q[c].size() > 0));
                checkOutput($sformatf("acc_rdy[%0d]", c), 64'(acc_rdy_o[c]),
                            64'((c < NFIFO) && (rx_q[c].size() < DEPTH)));
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (acc_rdy_i[c] && tx_q[c].size() > 0) begin
                head = tx_q[c].pop_front();
                checkOutput($sformatf("acc_dat[%0d]", c), 64'(acc_dat_o[c*32 +: 32]), 64'(head[31:0]));
                checkOutput($sformatf("acc_tag[%0d]", c), 64'(acc_tag_o[c]), 64'(head[32]));
            end
        end
    end

    initial begin
        doReset();

        // Single put, accelerator not taking: head visible with tag.
        applyStimulus(1'b1, 2, 32'hDEADBEEF, 1'b1, 1'b1, 6, lat);
        checkOutput("put2_lat", 64'(lat), 64'd1);
        checkOutput("put2_vld", 64'(acc_vld_o[2]), 64'd1);
        checkOutput("put2_dat", 64'(acc_dat_o[2*32 +: 32]), 64'hDEADBEEF);
        checkOutput("put2_tag", 64'(acc_tag_o[2]), 64'd1);

        // Fill TX ch0; fifth put stalls until one word is drained.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 0, 32'h100 + 32'(i), i[0], 1'b1, 6, lat);
            checkOutput("put0_lat", 64'(lat), 64'd1);
        end
        fork
            applyStimulus(1'b1, 0, 32'h1FF, 1'b0, 1'b1, 12, lat);
            begin
                repeat (3) @(posedge sys_clk_i);
                #1 acc_rdy_i[0] = 1'b1;
                @(posedge sys_clk_i);
                #1 acc_rdy_i[0] = 1'b0;
            end
        join
        checkOutput("put0_full_lat", 64'(lat), 64'd5);

        // Get from empty RX ch1 stalls until the accelerator supplies a word.
        fork
            applyStimulus(1'b0, 1, 32'h0, 1'b0, 1'b1, 12, lat);
            begin
                repeat (3) @(posedge sys_clk_i);
                #1;
                accPush(1, 32'h00000055);
            end
        join
        checkOutput("get1_lat", 64'(lat), 64'd5);

        // Fill RX ch3 and read it back in order.
        for (int i = 1; i <= DEPTH; i++) accPush(3, 32'(i));
        checkOutput("rx3_full_rdy", 64'(acc_rdy_o[3]), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 3, 32'h0, 1'b0, 1'b1, 6, lat);
            checkOutput("get3_lat", 64'(lat), 64'd1);
            if (i == 0) checkOutput("rx3_rdy_after_pop", 64'(acc_rdy_o[3]), 64'd1);
        end

        // Randomized mix of puts, gets, accelerator pushes and drains.
        for (int it = 0; it < 400; it++) begin
            int op;
            int ch;
            acc_rdy_i = NCH'($urandom);
            op = $urandom_range(0, 2);
            ch = $urandom_range(0, NFIFO - 1);
            case (op)
                0: if (tx_q[ch].size() < DEPTH) begin
                       applyStimulus(1'b1, ch, $urandom, 1'($urandom), 1'b1, 6, lat);
                       checkOutput("rand_put_lat", 64'(lat), 64'd1);
                   end
                1: if (rx_q[ch].size() > 0) begin
                       applyStimulus(1'b0, ch, 32'h0, 1'b0, 1'b1, 6, lat);
                       checkOutput("rand_get_lat", 64'(lat), 64'd1);
                   end
                default: if (rx_q[ch].size() < DEPTH) begin
                       accPush(ch, $urandom);
                   end else begin
                       @(posedge sys_clk_i);
                       #1;
                   end
            endcase
        end
        acc_rdy_i = '1;
        repeat (6) @(posedge sys_clk_i);
        #1 acc_rdy_i = '0;
        while (rx_q[4].size() > 0) begin
            applyStimulus(1'b0, 4, 32'h0, 1'b0, 1'b1, 6, lat);
            checkOutput("drain4_lat", 64'(lat), 64'd1);
        end
        @(posedge sys_clk_i);
        #1;

        // Reset in the middle of a blocked get: never acked.
        fork
            applyStimulus(1'b0, 4, 32'h0, 1'b0, 1'b0, 10, lat);
            begin
                repeat (2) @(posedge sys_clk_i);
                #1;
                doReset();
            end
        join
        checkOutput("rst_get_no_ack", 64'(lat), 64'(-1));
        checkOutput("rst_vld_all", 64'(acc_vld_o), 64'd0);
        applyStimulus(1'b1, 5, 32'hCAFE0005, 1'b0, 1'b1, 6, lat);
        checkOutput("post_rst_put_lat", 64'(lat), 64'd1);

`ifdef AEMB2_XSLV_STAT_EN
        accPush(0, 32'h12345678);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 1, 32'(i), 1'b0, 1'b1, 6, lat);
            checkOutput("stat_fill_lat", 64'(lat), 64'd1);
        end
        applyStimulus(1'b0, NCH - 1, 32'h0, 1'b0, 1'b1, 6, lat);
        checkOutput("stat_get_lat", 64'(lat), 64'd1);
        applyStimulus(1'b1, NCH - 1, 32'hFFFF0000, 1'b1, 1'b1, 6, lat);
        checkOutput("stat_put_lat", 64'(lat), 64'd1);
`else
        applyStimulus(1'b0, NCH - 1, 32'h0, 1'b0, 1'b0, 5, lat);
        checkOutput("ch7_get_blocks", 64'(lat), 64'(-1));
`endif

        acc_rdy_i = '1;
        repeat (4) @(posedge sys_clk_i);
        #1;
        checkOutput("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
